// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-FIFO-side signals of the UART TX arbiter.
// The master modport drives requests and the FIFO flag. The slave modport is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 tx_fifo_full_i;
  logic                 tx_fifo_write_o;
  logic [7:0]           data_tx_o;
  logic [GW-1:0]        grant_id_o;
  logic                 busy_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_fifo_full_i,
    input  req_ready_o, tx_fifo_write_o, data_tx_o, grant_id_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_fifo_full_i,
    output req_ready_o, tx_fifo_write_o, data_tx_o, grant_id_o, busy_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges byte streams from NUM_REQ requesters into one UART TX FIFO.
// Grants are bounded by packet end, MAX_BURST bytes, or STALL_LIMIT idle cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_tx_arbiter_if.slave  bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [GW-1:0] LAST_IDX   = GW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [7:0]    STALL_LAST = 8'(STALL_LIMIT - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      rr_ptr, rr_nxt;
  logic [GW-1:0]      grant, grant_nxt;
  logic [GW-1:0]      pick_idx, scan_idx;
  logic               pick_found;
  logic [BW-1:0]      burst_cnt, burst_nxt;
  logic [7:0]         stall_cnt, stall_nxt;
  logic               accept;
  logic [NUM_REQ-1:0] ready;
  logic [7:0]         data_p0;
  logic               vld_p1;
  logic [7:0]         data_p1;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Scan once around the ring starting at rr_ptr; the first valid index wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && bus.req_valid_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant;
    burst_nxt = burst_cnt;
    stall_nxt = stall_cnt;
    accept    = 1'b0;
    ready     = '0;
    data_p0   = bus.req_data_i[{grant, 3'b000} +: 8];
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = XFER;
          grant_nxt = pick_idx;
          burst_nxt = '0;
          stall_nxt = '0;
        end
      end
      XFER: begin
        accept = bus.req_valid_i[grant] && !bus.tx_fifo_full_i;
        if (accept) begin
          ready[grant] = 1'b1;
          stall_nxt    = '0;
          burst_nxt    = burst_cnt + 1'b1;
          if (bus.req_last_i[grant] || burst_cnt == BURST_LAST) begin
            state_nxt = IDLE;
            rr_nxt    = next_idx(grant);
          end
        end else if (!bus.req_valid_i[grant] && !bus.tx_fifo_full_i) begin
          // A full FIFO is back-pressure, not an idle grantee, so it never ages the grant.
          if (stall_cnt == STALL_LAST) begin
            state_nxt = IDLE;
            rr_nxt    = next_idx(grant);
          end else begin
            stall_nxt = stall_cnt + 1'b1;
          end
        end
      end
    endcase
    if (rst_i) begin
      accept = 1'b0;
      ready  = '0;
    end
  end

  // p0 -> p1: accepted byte registered toward the FIFO write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant     <= grant_nxt;
      burst_cnt <= burst_nxt;
      stall_cnt <= stall_nxt;
      vld_p1    <= accept;
      if (accept) data_p1 <= data_p0;
    end
  end

  assign bus.req_ready_o     = ready;
  assign bus.tx_fifo_write_o = vld_p1;
  assign bus.data_tx_o       = data_p1;
  assign bus.grant_id_o      = grant;
  assign bus.busy_o          = (state == XFER);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs change on the falling edge, outputs are checked 1 time unit later.
// Defaults used: NUM_REQ=4, MAX_BURST=16, STALL_LIMIT=64.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_BURST(16),
    .STALL_LIMIT(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int w, input int d, input int b);
    chk({tag, ".write"}, 32'(bus.tx_fifo_write_o), w);
    if (w == 1) chk({tag, ".data"}, 32'(bus.data_tx_o), d);
    chk({tag, ".busy"}, 32'(bus.busy_o), b);
  endtask

  task automatic xfer(input string tag, input int g, input int rdy);
    chk({tag, ".grant"}, 32'(bus.grant_id_o), g);
    chk({tag, ".ready"}, 32'(bus.req_ready_o), rdy);
    chk({tag, ".busy"}, 32'(bus.busy_o), 1);
  endtask

  task automatic setd(input int r, input logic [7:0] b);
    bus.req_data_i[8*r +: 8] = b;
  endtask

  initial begin
    rst                = 1'b1;
    bus.req_valid_i    = '0;
    bus.req_data_i     = '0;
    bus.req_last_i     = '0;
    bus.tx_fifo_full_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    outs("reset", 0, 0, 0);
    chk("reset.data", 32'(bus.data_tx_o), 0);
    chk("reset.grant", 32'(bus.grant_id_o), 0);
    chk("reset.ready", 32'(bus.req_ready_o), 0);

    // Requesters 0 and 2, three-byte packets each
    @(negedge clk); rst = 1'b0; bus.req_valid_i = 4'b0101; setd(0, 8'hA0); setd(2, 8'hC0); #1;
    outs("t30.idle", 0, 0, 0);
    chk("t30.idle.ready", 32'(bus.req_ready_o), 0);
    @(negedge clk); #1;
    xfer("t30.g0", 0, 'b0001);
    outs("t30.g0", 0, 0, 1);
    @(negedge clk); setd(0, 8'hA1); #1;
    outs("t30.a0", 1, 'hA0, 1);
    chk("t30.a0.ready", 32'(bus.req_ready_o), 'b0001);
    @(negedge clk); setd(0, 8'hA2); bus.req_last_i = 4'b0001; #1;
    outs("t30.a1", 1, 'hA1, 1);
    @(negedge clk); bus.req_valid_i = 4'b0100; bus.req_last_i = 4'b0000; #1;
    outs("t30.a2", 1, 'hA2, 0);
    chk("t30.a2.ready", 32'(bus.req_ready_o), 0);
    @(negedge clk); #1;
    xfer("t30.g2", 2, 'b0100);
    outs("t30.g2", 0, 0, 1);
    @(negedge clk); setd(2, 8'hC1); #1;
    outs("t30.c0", 1, 'hC0, 1);
    @(negedge clk); setd(2, 8'hC2); bus.req_last_i = 4'b0100; #1;
    outs("t30.c1", 1, 'hC1, 1);
    @(negedge clk); bus.req_valid_i = 4'b0000; bus.req_last_i = 4'b0000; #1;
    outs("t30.c2", 1, 'hC2, 0);

    // rr_ptr is now 3: with 0, 1 and 3 valid, requester 3 must win
    @(negedge clk); bus.req_valid_i = 4'b1011; bus.req_last_i = 4'b1111;
    setd(0, 8'h30); setd(1, 8'h31); setd(3, 8'h33); #1;
    outs("t30.rr", 0, 0, 0);
    @(negedge clk); #1;
    xfer("t30.rr3", 3, 'b1000);
    @(negedge clk); bus.req_valid_i = 4'b0000; bus.req_last_i = 4'b0000; #1;
    outs("t30.d3", 1, 'h33, 0);

    // Requester 1 streams 20 bytes with no last: 16 bytes, then a re-grant, then 4 bytes
    @(negedge clk); bus.req_valid_i = 4'b0010; setd(1, 8'h40); #1;
    outs("t31.idle", 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); setd(1, 8'('h40 + i)); #1;
      chk($sformatf("t31.b%0d.ready", i), 32'(bus.req_ready_o), 'b0010);
      if (i == 0) begin
        xfer("t31.g1", 1, 'b0010);
        outs("t31.g1", 0, 0, 1);
      end else begin
        outs($sformatf("t31.b%0d", i), 1, 'h40 + i - 1, 1);
      end
    end
    @(negedge clk); setd(1, 8'h50); #1;
    outs("t31.cap", 1, 'h4F, 0);
    chk("t31.cap.ready", 32'(bus.req_ready_o), 0);
    for (int i = 16; i < 20; i++) begin
      @(negedge clk); setd(1, 8'('h40 + i)); bus.req_last_i = (i == 19) ? 4'b0010 : 4'b0000; #1;
      chk($sformatf("t31.b%0d.ready", i), 32'(bus.req_ready_o), 'b0010);
      if (i == 16) begin
        xfer("t31.regrant", 1, 'b0010);
        outs("t31.regrant", 0, 0, 1);
      end else begin
        outs($sformatf("t31.b%0d", i), 1, 'h40 + i - 1, 1);
      end
    end
    @(negedge clk); bus.req_valid_i = 4'b0000; bus.req_last_i = 4'b0000; #1;
    outs("t31.end", 1, 'h53, 0);

    // FIFO full for 5 cycles in the middle of a 4-byte packet from requester 2
    @(negedge clk); bus.req_valid_i = 4'b0100; setd(2, 8'h60); #1;
    outs("t32.idle", 0, 0, 0);
    @(negedge clk); #1;
    xfer("t32.g2", 2, 'b0100);
    @(negedge clk); setd(2, 8'h61); #1;
    outs("t32.b0", 1, 'h60, 1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); bus.tx_fifo_full_i = 1'b1; setd(2, 8'h62); #1;
      chk($sformatf("t32.full%0d.ready", j), 32'(bus.req_ready_o), 0);
      if (j == 0) outs("t32.full0", 1, 'h61, 1);
      else        outs($sformatf("t32.full%0d", j), 0, 0, 1);
    end
    @(negedge clk); bus.tx_fifo_full_i = 1'b0; #1;
    chk("t32.resume.ready", 32'(bus.req_ready_o), 'b0100);
    outs("t32.resume", 0, 0, 1);
    @(negedge clk); setd(2, 8'h63); bus.req_last_i = 4'b0100; #1;
    outs("t32.b2", 1, 'h62, 1);
    @(negedge clk); bus.req_valid_i = 4'b0000; bus.req_last_i = 4'b0000; #1;
    outs("t32.b3", 1, 'h63, 0);

    // Grantee 0 goes quiet after one byte; requester 3 waits through the 64-cycle stall
    @(negedge clk); bus.req_valid_i = 4'b0001; setd(0, 8'h70); #1;
    outs("t33.idle", 0, 0, 0);
    @(negedge clk); #1;
    xfer("t33.g0", 0, 'b0001);
    @(negedge clk); bus.req_valid_i = 4'b1000; setd(3, 8'h80); bus.req_last_i = 4'b1000; #1;
    outs("t33.a0", 1, 'h70, 1);
    chk("t33.a0.ready", 32'(bus.req_ready_o), 0);
    for (int k = 2; k <= 64; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t33.hold%0d.busy", k), 32'(bus.busy_o), 1);
      chk($sformatf("t33.hold%0d.ready", k), 32'(bus.req_ready_o), 0);
    end
    @(negedge clk); #1;
    outs("t33.revoke", 0, 0, 0);
    @(negedge clk); #1;
    xfer("t33.g3", 3, 'b1000);
    @(negedge clk); bus.req_valid_i = 4'b0000; bus.req_last_i = 4'b0000; #1;
    outs("t33.d3", 1, 'h80, 0);

    // Reset during byte 2 of a 4-byte packet from requester 3 (rr_ptr moved to 3 first)
    @(negedge clk); bus.req_valid_i = 4'b0100; setd(2, 8'hB0); bus.req_last_i = 4'b0100; #1;
    outs("t34.idle", 0, 0, 0);
    @(negedge clk); #1;
    xfer("t34.g2", 2, 'b0100);
    @(negedge clk); bus.req_valid_i = 4'b1000; setd(3, 8'hD0); bus.req_last_i = 4'b0000; #1;
    outs("t34.b0", 1, 'hB0, 0);
    @(negedge clk); #1;
    xfer("t34.g3", 3, 'b1000);
    @(negedge clk); setd(3, 8'hD1); rst = 1'b1; #1;
    chk("t34.rst.ready", 32'(bus.req_ready_o), 0);
    outs("t34.rst", 1, 'hD0, 1);
    @(negedge clk); rst = 1'b0; bus.req_valid_i = 4'b1001; setd(0, 8'hE0); bus.req_last_i = 4'b0001; #1;
    outs("t34.after", 0, 0, 0);
    chk("t34.after.data", 32'(bus.data_tx_o), 0);
    chk("t34.after.grant", 32'(bus.grant_id_o), 0);
    chk("t34.after.ready", 32'(bus.req_ready_o), 0);
    @(negedge clk); #1;
    xfer("t34.low", 0, 'b0001);
    @(negedge clk); bus.req_valid_i = 4'b0000; bus.req_last_i = 4'b0000; #1;
    outs("t34.e0", 1, 'hE0, 0);

    // All four requesters with 1-byte packets: grants rotate 0,1,2,3,0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.req_valid_i = 4'b1111; bus.req_last_i = 4'b1111;
    for (int r = 0; r < NUM_REQ; r++) setd(r, 8'('h10 + r));
    #1;
    outs("t35.idle", 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      xfer($sformatf("t35.g%0d", k), k % 4, 1 << (k % 4));
      @(negedge clk); #1;
      outs($sformatf("t35.w%0d", k), 1, 'h10 + (k % 4), 0);
    end
    @(negedge clk); bus.req_valid_i = 4'b0000; bus.req_last_i = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
